// File: rtl/ch8_acc_requant.sv
// Eight-channel accumulate-and-requantize stage: sums N signed partial-sum beats
// on top of a per-channel bias, then applies a rounding right shift and saturation.
module ch8_acc_requant #(
    parameter int DW = 8,
    parameter int PW = 16,
    parameter int AW = 24,
    parameter int CW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [CW-1:0]          cfg_len,
    input  logic [4:0]             cfg_shift,
    input  logic [7:0][AW-1:0]     bias_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0][PW-1:0]     in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0][DW-1:0]     out_data
);

    typedef enum logic [1:0] {ACC, RND, OUT} state_t;

    localparam logic signed [AW:0] SAT_MAX = (AW+1)'((1 <<< (DW-1)) - 1);
    localparam logic signed [AW:0] SAT_MIN = -SAT_MAX - (AW+1)'(1);

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          len_q, len_d;
    logic [4:0]             shift_q, shift_d;
    logic [7:0][AW-1:0]     acc_q, acc_d;
    logic [7:0][DW-1:0]     out_data_q, out_data_d;

    logic [CW-1:0]          cfg_len_eff;
    logic                   accept;
    logic                   first_beat;
    logic                   last_beat;

    // Round half up then shift; the extra MSB keeps the rounding add from wrapping.
    function automatic logic signed [DW-1:0] round_sat(input logic signed [AW-1:0] a,
                                                       input logic [4:0] s);
        logic signed [AW:0] w;
        w = {a[AW-1], a};
        if (s != 5'd0) begin
            w = w + ((AW+1)'(1) <<< (s - 5'd1));
        end
        w = w >>> s;
        if (w > SAT_MAX) begin
            round_sat = SAT_MAX[DW-1:0];
        end else if (w < SAT_MIN) begin
            round_sat = SAT_MIN[DW-1:0];
        end else begin
            round_sat = w[DW-1:0];
        end
    endfunction

    function automatic logic [AW-1:0] sext(input logic [PW-1:0] v);
        sext = {{(AW-PW){v[PW-1]}}, v};
    endfunction

    assign cfg_len_eff = (cfg_len == '0) ? CW'(1) : cfg_len;
    assign accept      = in_valid & in_ready;
    assign first_beat  = (cnt_q == '0);
    assign last_beat   = first_beat ? (cfg_len_eff == CW'(1)) : ((cnt_q + CW'(1)) == len_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (accept && last_beat) state_d = RND;
            RND:     state_d = OUT;
            OUT:     if (out_ready) state_d = ACC;
            default: state_d = ACC;
        endcase
        if (clear) begin
            state_d = ACC;
        end
    end

    // Ready depends only on state and clear, never on in_valid.
    always_comb begin
        in_ready  = (state_q == ACC) && !clear;
        out_valid = (state_q == OUT);
    end

    always_comb begin
        cnt_d      = cnt_q;
        len_d      = len_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        if (clear) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                ACC: begin
                    if (accept) begin
                        if (first_beat) begin
                            for (int c = 0; c < 8; c++) begin
                                acc_d[c] = bias_in[c] + sext(in_data[c]);
                            end
                            len_d   = cfg_len_eff;
                            shift_d = cfg_shift;
                            cnt_d   = CW'(1);
                        end else begin
                            for (int c = 0; c < 8; c++) begin
                                acc_d[c] = acc_q[c] + sext(in_data[c]);
                            end
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                RND: begin
                    for (int c = 0; c < 8; c++) begin
                        out_data_d[c] = round_sat(acc_q[c], shift_q);
                    end
                end
                OUT: begin
                    if (out_ready) cnt_d = '0;
                end
                default: cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            len_q      <= '0;
            shift_q    <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_data = out_data_q;

endmodule

// File: tb/tb_ch8_acc_requant.sv
// Directed bench for ch8_acc_requant: one task per scenario, inline checks.
module tb_ch8_acc_requant;

    typedef logic [7:0][15:0] vec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               clear;
    logic [7:0]         cfg_len;
    logic [4:0]         cfg_shift;
    logic [7:0][23:0]   bias_in;
    logic               in_valid;
    logic               in_ready;
    vec_t               in_data;
    logic               out_valid;
    logic               out_ready;
    logic [7:0][7:0]    out_data;

    int total = 0;
    int bad   = 0;

    ch8_acc_requant #(.DW(8), .PW(16), .AW(24), .CW(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .cfg_len(cfg_len), .cfg_shift(cfg_shift),
        .bias_in(bias_in), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int a, input int b, input int c);
        mk = '0;
        mk[0] = 16'(a);
        mk[1] = 16'(b);
        mk[2] = 16'(c);
    endfunction

    // Presents one beat at a falling edge; returns at the next falling edge.
    task automatic beat(input vec_t d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = out_valid;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 64'h0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        clear = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL clear_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_single_beat;
        cfg_len = 8'd1; cfg_shift = 5'd0; bias_in = '0; out_ready = 1'b1;
        beat(mk(5, -3, 0));
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL n1_lat_rnd got=%b exp=0", out_valid); end
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL n1_lat_out got=%b exp=1", out_valid); end
        total++; if (out_data !== 64'h0000_0000_0000_FD05) begin bad++; $display("FAIL n1_data got=%h exp=%h", out_data, 64'h0000_0000_0000_FD05); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL n1_hs_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL n1_hs_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_accumulate;
        bit ok;
        cfg_len = 8'd4; cfg_shift = 5'd2; bias_in = '0;
        bias_in[0] = 24'd2; bias_in[1] = 24'd2;
        beat(mk(10, -10, 1));
        // Config and bias changes after the first beat must not affect this group.
        bias_in[0] = 24'd100; cfg_len = 8'd1; cfg_shift = 5'd0;
        beat(mk(10, -10, 1));
        beat(mk(10, -10, 1));
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL n4_early_valid got=%b exp=0", out_valid); end
        beat(mk(10, -10, 0));
        wait_out(ok);
        total++; if (!ok) begin bad++; $display("FAIL n4_timeout got=0 exp=1"); end
        total++; if (out_data !== 64'h0000_0000_0001_F70B) begin bad++; $display("FAIL n4_data got=%h exp=%h", out_data, 64'h0000_0000_0001_F70B); end
        @(negedge clk);
        bias_in = '0;
    endtask

    task automatic test_saturate_round;
        bit ok;
        cfg_len = 8'd1; cfg_shift = 5'd0; bias_in = '0;
        beat(mk(300, -300, 0));
        wait_out(ok);
        total++; if (!ok) begin bad++; $display("FAIL sat1_timeout got=0 exp=1"); end
        total++; if (out_data !== 64'h0000_0000_0000_807F) begin bad++; $display("FAIL sat1_data got=%h exp=%h", out_data, 64'h807F); end
        @(negedge clk);
        cfg_len = 8'd2; cfg_shift = 5'd4;
        beat(mk(0, 0, 2000));
        beat(mk(0, 0, 2000));
        wait_out(ok);
        total++; if (!ok) begin bad++; $display("FAIL sat2_timeout got=0 exp=1"); end
        total++; if (out_data !== 64'h0000_0000_007F_0000) begin bad++; $display("FAIL sat2_data got=%h exp=%h", out_data, 64'h7F0000); end
        @(negedge clk);
        // Length 0 behaves as 1; -1.5 rounds to -1, 1.5 rounds to 2.
        cfg_len = 8'd0; cfg_shift = 5'd1;
        beat(mk(-3, 3, 0));
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL len0_lat got=%b exp=0", out_valid); end
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL len0_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 64'h0000_0000_0000_02FF) begin bad++; $display("FAIL len0_round got=%h exp=%h", out_data, 64'h02FF); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        bit ok;
        logic [63:0] held;
        cfg_len = 8'd1; cfg_shift = 5'd0; bias_in = '0; out_ready = 1'b0;
        beat(mk(20, 0, 0));
        wait_out(ok);
        held = out_data;
        total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=0 exp=1"); end
        total++; if (held !== 64'h14) begin bad++; $display("FAIL bp_data got=%h exp=%h", held, 64'h14); end
        in_valid = 1'b1;
        in_data  = mk(3, 0, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_%0d got=%b exp=1", i, out_valid); end
            total++; if (out_data !== held) begin bad++; $display("FAIL bp_stable_%0d got=%h exp=%h", i, out_data, held); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_%0d got=%b exp=0", i, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_hs_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_hs_ready got=%b exp=1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_held_timeout got=0 exp=1"); end
        total++; if (out_data !== 64'h03) begin bad++; $display("FAIL bp_held_data got=%h exp=%h", out_data, 64'h03); end
        @(negedge clk);
    endtask

    task automatic test_rst_mid_group;
        bit ok;
        cfg_len = 8'd4; cfg_shift = 5'd0; bias_in = '0; out_ready = 1'b1;
        beat(mk(7, 0, 0));
        beat(mk(7, 0, 0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
        for (int i = 0; i < 4; i++) beat(mk(1, 0, 0));
        wait_out(ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_timeout got=0 exp=1"); end
        total++; if (out_data !== 64'h04) begin bad++; $display("FAIL rstmid_data got=%h exp=%h", out_data, 64'h04); end
        @(negedge clk);
    endtask

    task automatic test_clear;
        bit ok;
        cfg_len = 8'd1; cfg_shift = 5'd0; bias_in = '0; out_ready = 1'b0;
        beat(mk(50, 0, 0));
        wait_out(ok);
        total++; if (!ok) begin bad++; $display("FAIL clr_timeout got=0 exp=1"); end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 64'h32) begin bad++; $display("FAIL clr_data_kept got=%h exp=%h", out_data, 64'h32); end
        // A beat presented together with clear must be dropped.
        clear = 1'b1; in_valid = 1'b1; in_data = mk(100, 0, 0);
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_beat_dropped got=%b exp=0", out_valid); end
        out_ready = 1'b1;
        beat(mk(9, 0, 0));
        wait_out(ok);
        total++; if (!ok) begin bad++; $display("FAIL clr_next_timeout got=0 exp=1"); end
        total++; if (out_data !== 64'h09) begin bad++; $display("FAIL clr_next_data got=%h exp=%h", out_data, 64'h09); end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; cfg_len = 8'd1; cfg_shift = 5'd0; bias_in = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        test_reset();
        test_single_beat();
        test_accumulate();
        test_saturate_round();
        test_backpressure();
        test_rst_mid_group();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ch8_acc_requant.md
# ch8_acc_requant

Eight-channel accumulate-and-requantize stage that sits directly upstream of the 8-channel ReLU in the fdt datapath. It sums a configurable number of signed partial-sum vectors per channel on top of a per-channel bias. It then applies a rounding arithmetic right shift and saturates each channel to DW-bit signed. The result is a packed 8×DW vector presented with a valid/ready handshake, ready to feed the ReLU input directly.

## Interface
- DW, 8, output element width (signed), matches ReLU DW
- PW, 16, input partial-sum element width (signed)
- AW, 24, accumulator and bias width (signed); AW > PW, AW > DW
- CW, 8, width of cfg_len
- clk  in  1  clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous soft clear, aborts the current group
- cfg_len  in  CW  beats per group N (unsigned); 0 treated as 1
- cfg_shift  in  5  right-shift amount S, legal range 0..AW-1
- bias_in  in  [7:0][AW-1:0]  per-channel signed bias
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  [7:0][PW-1:0]  per-channel signed partial sums
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- out_data  out  [7:0][DW-1:0]  per-channel signed saturated result

## Operation
- One clock; reset is asynchronous and active-high (clk, rst).
- States: ACC, RND, OUT. Reset and clear both go to ACC.
- ACC:
  - in_ready = 1.
  - First accepted beat of a group:
    - acc[c] = bias_in[c] + sext(in_data[c]).
    - cfg_len and cfg_shift are latched.
    - cnt = 1.
  - Later beats: acc[c] += sext(in_data[c]); cnt++.
  - When the accepted beat makes cnt == N, go to RND.
  - If N == 1, the first beat goes straight to RND.
- RND (exactly 1 cycle):
  - in_ready = 0.
  - r[c] = (acc[c] + (S ? 2^(S-1) : 0)) >>> S, computed in AW+1 bits so the round add cannot wrap.
  - r[c] saturates to [-2^(DW-1), 2^(DW-1)-1].
  - out_data is registered; next state is OUT.
- OUT:
  - out_valid = 1, in_ready = 0.
  - out_data is held stable until out_ready.
  - On handshake: out_valid = 0, cnt = 0, next state is ACC.
- Arithmetic:
  - Accumulation wraps modulo 2^AW; there is no overflow saturation.
  - Rounding is round-half-up (toward +inf).
- clear:
  - Synchronous, highest priority over all transitions.
  - Next cycle: state ACC, cnt = 0, out_valid = 0.
  - out_data keeps its last value.
  - A beat presented in the clear cycle is not accepted (in_ready = 0 while clear is high).
- bias_in is sampled only on the first beat of a group. Later changes have no effect on that group.

## Timing
- Reset values:
  - state ACC, cnt 0, acc 0.
  - out_valid 0, out_data all 0.
  - in_ready 1 after rst deasserts (0 while clear is high).
- in_ready = (state == ACC) & ~clear. It is combinational from state, with no input-to-ready path.
- Latency: last beat accepted at edge t → out_valid high after edge t+1.
- Throughput: N+2 cycles per group minimum (N beats, RND, one OUT cycle with out_ready high).
- Backpressure:
  - out_valid is never dropped without a handshake (except rst or clear).
  - out_data is stable while out_valid & ~out_ready.
- rst mid-group: the partial accumulation is discarded, and the next accepted beat starts a fresh group.
- in_valid gaps during ACC simply stall accumulation. No timeout.

## Test plan
- N=1, S=0, bias 0, in ch0=5, ch1=-3, other channels 0 → out ch0=0x05, ch1=0xFD, rest 0; out_valid 2 cycles after the beat cycle.
- N=4, S=2, bias 2; ch0 = 10 ×4 → 11 (44>>2); ch1 = -10 ×4 → -9 (0xF7); ch2 = 1,1,1,0 with bias 0 → 1 (round half up of 0.75).
- Saturation: N=1, S=0, ch0=300 → 127 (0x7F); ch1=-300 → -128 (0x80); N=2, S=4, ch2=2000 ×2 → 127.
- Backpressure: out_ready low 5 cycles after out_valid rises → out_data constant, in_ready 0, held in_valid beat not accepted. out_ready high → handshake, in_ready 1 next cycle, held beat then accepted.
- rst asserted after 2 of 4 beats (ch0 = 7 each), then 4 new beats of ch0 = 1, N=4, S=0, bias 0 → out ch0 = 4, not 18.
- clear pulse during OUT → out_valid 0 next cycle, out_data unchanged. Following group (N=1, ch0=9) → out ch0 = 9.
